// File: rtl/seg7_mmss_scan.sv
// rtl/seg7_mmss_scan.sv - MM:SS BCD run/clear counter multiplexed onto a 4-digit 7-segment display
module seg7_mmss_scan #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick_1s,
    input  logic        tick_scan,
    input  logic        run,
    input  logic        clr,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [7:0]  seg,
    output logic [3:0]  dig_sel
);

    typedef enum logic [1:0] {
        SCAN_D0 = 2'd0,
        SCAN_D1 = 2'd1,
        SCAN_D2 = 2'd2,
        SCAN_D3 = 2'd3
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [3:0] DIG_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic        r_tick_1s_q;
    logic        r_tick_scan_q;
    logic [15:0] r_count;
    logic        r_wrap;
    scan_state_t r_scan;
    logic [7:0]  r_seg;
    logic [3:0]  r_dig;

    logic        w_s1_edge;
    logic        w_scan_edge;
    logic [15:0] w_count_inc;
    logic        w_rollover;
    scan_state_t w_scan_next;
    logic [3:0]  w_nibble;
    logic [6:0]  w_dec;
    logic        w_dp;
    logic [7:0]  w_seg_raw;
    logic [3:0]  w_dig_raw;

    // History regs reset high so a level already high at reset release is not an edge.
    assign w_s1_edge   = tick_1s & ~r_tick_1s_q;
    assign w_scan_edge = tick_scan & ~r_tick_scan_q;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_tick_1s_q   <= 1'b1;
            r_tick_scan_q <= 1'b1;
        end else begin
            r_tick_1s_q   <= tick_1s;
            r_tick_scan_q <= tick_scan;
        end
    end

    always_comb begin
        w_count_inc = r_count;
        w_rollover  = (r_count == 16'h5959);
        if (r_count[3:0] != 4'd9) begin
            w_count_inc[3:0] = r_count[3:0] + 4'd1;
        end else begin
            w_count_inc[3:0] = 4'd0;
            if (r_count[7:4] != 4'd5) begin
                w_count_inc[7:4] = r_count[7:4] + 4'd1;
            end else begin
                w_count_inc[7:4] = 4'd0;
                if (r_count[11:8] != 4'd9) begin
                    w_count_inc[11:8] = r_count[11:8] + 4'd1;
                end else begin
                    w_count_inc[11:8] = 4'd0;
                    if (r_count[15:12] != 4'd5) begin
                        w_count_inc[15:12] = r_count[15:12] + 4'd1;
                    end else begin
                        w_count_inc[15:12] = 4'd0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_count <= 16'h0000;
            r_wrap  <= 1'b0;
        end else if (clr) begin
            r_count <= 16'h0000;
            r_wrap  <= 1'b0;
        end else if (w_s1_edge && run) begin
            r_count <= w_count_inc;
            r_wrap  <= w_rollover;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    always_comb begin
        w_scan_next = r_scan;
        if (w_scan_edge) begin
            case (r_scan)
                SCAN_D0: w_scan_next = SCAN_D1;
                SCAN_D1: w_scan_next = SCAN_D2;
                SCAN_D2: w_scan_next = SCAN_D3;
                default: w_scan_next = SCAN_D0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_scan <= SCAN_D0;
        end else begin
            r_scan <= w_scan_next;
        end
    end

    always_comb begin
        w_nibble = r_count[{r_scan, 2'b00} +: 4];
        w_dec    = 7'h00;
        case (w_nibble)
            4'd0:    w_dec = 7'h3F;
            4'd1:    w_dec = 7'h06;
            4'd2:    w_dec = 7'h5B;
            4'd3:    w_dec = 7'h4F;
            4'd4:    w_dec = 7'h66;
            4'd5:    w_dec = 7'h6D;
            4'd6:    w_dec = 7'h7D;
            4'd7:    w_dec = 7'h07;
            4'd8:    w_dec = 7'h7F;
            4'd9:    w_dec = 7'h6F;
            default: w_dec = 7'h00;
        endcase
        // Decimal point on min_lo blinks with the 1 s square wave as the colon.
        w_dp      = (r_scan == SCAN_D2) & tick_1s;
        w_seg_raw = {w_dp, w_dec};
        w_dig_raw = 4'b0001 << r_scan;
    end

    // Segment and digit registers load together so digits never ghost.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_seg <= SEG_OFF;
            r_dig <= DIG_OFF;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
            r_dig <= DIG_ACTIVE_LOW ? ~w_dig_raw : w_dig_raw;
        end
    end

    assign count_bcd = r_count;
    assign wrap      = r_wrap;
    assign seg       = r_seg;
    assign dig_sel   = r_dig;

endmodule

// File: tb/tb_seg7_mmss_scan.sv
// tb/tb_seg7_mmss_scan.sv - scoreboard bench for the MM:SS counter and display scanner
module tb_seg7_mmss_scan;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        tick_1s = 1'b0;
    logic        tick_scan = 1'b0;
    logic        run = 1'b1;
    logic        clr = 1'b0;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;

    seg7_mmss_scan #(
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .tick_1s  (tick_1s),
        .tick_scan(tick_scan),
        .run      (run),
        .clr      (clr),
        .count_bcd(count_bcd),
        .wrap     (wrap),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_entry_t;

    localparam int SEL_COUNT = 0;
    localparam int SEL_WRAPS = 1;
    localparam int SEL_SEG   = 2;
    localparam int SEL_DIG   = 3;
    localparam int SEL_WRAP  = 4;

    sb_entry_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;
    int wrap_cnt = 0;
    int m_sec = 0;
    int m_idx = 0;
    int m_wraps = 0;
    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always @(posedge clk_in) begin
        #1;
        if (wrap === 1'b1) wrap_cnt++;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int mn, sc;
        mn = s / 60;
        sc = s % 60;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [7:0] seg_exp(input int idx, input int s, input logic t1s);
        logic [15:0] b;
        logic [3:0]  nib;
        b   = to_bcd(s);
        nib = b[idx*4 +: 4];
        return ~{(idx == 2) & t1s, seg_tbl[nib]};
    endfunction

    function automatic logic [3:0] dig_exp(input int idx);
        return ~(4'b0001 << idx);
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        sb_entry_t e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_COUNT: obs = {16'h0, count_bcd};
                SEL_WRAPS: obs = wrap_cnt;
                SEL_SEG:   obs = {24'h0, seg};
                SEL_DIG:   obs = {28'h0, dig_sel};
                default:   obs = {31'h0, wrap};
            endcase
            chk_val(e.tag, obs, e.exp);
        end
    endtask

    task automatic s1_edges(input int n);
        repeat (n) begin
            @(negedge clk_in);
            tick_1s = 1'b1;
            if (clr) m_sec = 0;
            else if (run) begin
                if (m_sec == 3599) m_wraps++;
                m_sec = (m_sec + 1) % 3600;
            end
            @(negedge clk_in);
            tick_1s = 1'b0;
        end
    endtask

    task automatic push_display(input string tag, input logic t1s);
        sb_push({tag, "_seg"}, SEL_SEG, {24'h0, seg_exp(m_idx, m_sec, t1s)});
        sb_push({tag, "_dig"}, SEL_DIG, {28'h0, dig_exp(m_idx)});
    endtask

    task automatic scan_step(input string tag);
        @(negedge clk_in);
        tick_scan = 1'b1;
        push_display({tag, "_hold"}, 1'b0);
        @(negedge clk_in);
        tick_scan = 1'b0;
        sb_drain();
        m_idx = (m_idx + 1) % 4;
        push_display(tag, 1'b0);
        @(negedge clk_in);
        sb_drain();
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        sb_push("rst_count", SEL_COUNT, 32'h0);
        sb_push("rst_wrap", SEL_WRAP, 32'h0);
        sb_push("rst_seg", SEL_SEG, 32'hFF);
        sb_push("rst_dig", SEL_DIG, 32'hF);
        sb_drain();
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        push_display("idle_disp", 1'b0);
        sb_drain();

        s1_edges(10);
        sb_push("count_10", SEL_COUNT, {16'h0, to_bcd(m_sec)});
        sb_push("count_10_lit", SEL_COUNT, 32'h0010);
        sb_push("no_wrap_10", SEL_WRAPS, 32'(m_wraps));
        sb_drain();

        @(negedge clk_in); clr = 1'b1; m_sec = 0;
        @(negedge clk_in); clr = 1'b0;
        s1_edges(7);
        sb_push("count_07", SEL_COUNT, 32'h0007);
        sb_drain();
        @(negedge clk_in);
        tick_1s = 1'b1; clr = 1'b1; m_sec = 0;
        sb_push("clr_beats_edge", SEL_COUNT, 32'h0000);
        @(negedge clk_in);
        sb_drain();
        tick_1s = 1'b0; clr = 1'b0;

        s1_edges(42);
        sb_push("count_42", SEL_COUNT, 32'h0042);
        sb_drain();
        run = 1'b0;
        s1_edges(5);
        run = 1'b1;
        repeat (3) @(negedge clk_in);
        sb_push("hold_42", SEL_COUNT, {16'h0, to_bcd(m_sec)});
        sb_drain();
        s1_edges(1);
        sb_push("resume_43", SEL_COUNT, 32'h0043);
        sb_drain();

        @(negedge clk_in); clr = 1'b1; m_sec = 0;
        @(negedge clk_in); clr = 1'b0;
        s1_edges(3599);
        sb_push("count_5959", SEL_COUNT, 32'h5959);
        sb_push("pre_wrap", SEL_WRAPS, 32'(m_wraps));
        sb_drain();
        @(negedge clk_in);
        tick_1s = 1'b1;
        m_sec = 0; m_wraps++;
        sb_push("wrap_count", SEL_COUNT, 32'h0000);
        sb_push("wrap_high", SEL_WRAP, 32'h1);
        @(negedge clk_in);
        sb_drain();
        tick_1s = 1'b0;
        repeat (3) @(negedge clk_in);
        sb_push("wrap_once", SEL_WRAPS, 32'(m_wraps));
        sb_push("wrap_low", SEL_WRAP, 32'h0);
        sb_drain();

        @(negedge clk_in); clr = 1'b1; m_sec = 0;
        @(negedge clk_in); clr = 1'b0;
        s1_edges(12 * 60 + 34);
        sb_push("count_1234", SEL_COUNT, 32'h1234);
        @(negedge clk_in);
        push_display("d0_start", 1'b0);
        sb_push("d0_seg_lit", SEL_SEG, 32'h99);
        sb_drain();
        scan_step("d1");
        sb_push("d1_seg_lit", SEL_SEG, 32'hB0);
        sb_drain();
        scan_step("d2");
        sb_push("d2_seg_lit", SEL_SEG, 32'hA4);
        sb_drain();
        run = 1'b0;
        @(negedge clk_in);
        tick_1s = 1'b1;
        @(negedge clk_in);
        push_display("d2_dp", 1'b1);
        sb_push("d2_dp_lit", SEL_SEG, 32'h24);
        sb_drain();
        tick_1s = 1'b0;
        @(negedge clk_in);
        sb_push("d2_dp_off", SEL_SEG, 32'hA4);
        sb_push("hold_1234", SEL_COUNT, 32'h1234);
        sb_drain();
        run = 1'b1;
        scan_step("d3");
        sb_push("d3_seg_lit", SEL_SEG, 32'hF9);
        sb_drain();
        scan_step("d0_wrap");

        @(negedge clk_in);
        rst = 1'b0; tick_1s = 1'b1;
        m_sec = 0; m_idx = 0;
        @(negedge clk_in);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        sb_push("high_at_release", SEL_COUNT, 32'h0000);
        sb_drain();
        tick_1s = 1'b0;
        s1_edges(1);
        @(negedge clk_in);
        sb_push("first_real_edge", SEL_COUNT, 32'h0001);
        push_display("post_rst", 1'b0);
        sb_drain();
        rst = 1'b0;
        #1;
        sb_push("async_seg", SEL_SEG, 32'hFF);
        sb_push("async_dig", SEL_DIG, 32'hF);
        sb_push("async_count", SEL_COUNT, 32'h0);
        sb_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
